seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Purpose : sequential restoring divider, one quotient bit per clock, unsigned (optionally two's complement).
// Latency : WIDTH+2 edges from the accepting edge to done (2 edges when divisor is zero).
// Backpr. : start is sampled only when idle (busy=0); start while busy is ignored, start during done is accepted.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a division (sampled in IDLE only)
//   dividend, divisor   operands, captured on the accepting edge
//   busy                high from the accepting edge until the result edge
//   done                one-cycle pulse, results valid
//   quotient, remainder registered results, held until the next done
//   div_by_zero         registered flag, updated with each done
//
// Build option: define DIV_SIGNED_EN for two's-complement operands/results.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;    // partial remainder
    logic [WIDTH-1:0] dvd;    // dividend bits shift out the top, quotient bits shift in the bottom
    logic [WIDTH-1:0] dvs;
    logic             dz;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

`ifdef DIV_SIGNED_EN
    logic dvd_neg;
    logic dvs_neg;

    // Divide magnitudes; -2^(WIDTH-1) maps onto itself, which is the correct unsigned magnitude.
    always_comb begin
        dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
        divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
    end

    // Quotient sign follows the operand signs, remainder sign follows the dividend.
    // On divide by zero dvd still holds the dividend magnitude, so re-signing it returns the dividend.
    always_comb begin
        q_fin = '1;
        r_fin = dvd_neg ? -dvd : dvd;
        if (!dz) begin
            q_fin = (dvd_neg ^ dvs_neg) ? -dvd : dvd;
            r_fin = dvd_neg ? -rem : rem;
        end
    end
`else
    always_comb begin
        dividend_mag = dividend;
        divisor_mag  = divisor;
    end

    always_comb begin
        q_fin = '1;
        r_fin = dvd;
        if (!dz) begin
            q_fin = dvd;
            r_fin = rem;
        end
    end
`endif

    // One restoring step: trial subtraction one bit wider than the operands, sign bit = borrow.
    always_comb begin
        shifted = {rem, dvd[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            rem         <= '0;
            dvd         <= '0;
            dvs         <= '0;
            dz          <= 1'b0;
`ifdef DIV_SIGNED_EN
            dvd_neg     <= 1'b0;
            dvs_neg     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dvd   <= dividend_mag;
                        dvs   <= divisor_mag;
                        rem   <= '0;
                        cnt   <= CNT_INIT;
                        busy  <= 1'b1;
                        dz    <= (divisor == '0);
`ifdef DIV_SIGNED_EN
                        dvd_neg <= dividend[WIDTH-1];
                        dvs_neg <= divisor[WIDTH-1];
`endif
                        state <= (divisor == '0) ? S_FINISH : S_CALC;
                    end
                end
                S_CALC: begin
                    rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                    dvd <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
                    if (cnt == '0) begin
                        state <= S_FINISH;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_FINISH: begin
                    quotient    <= q_fin;
                    remainder   <= r_fin;
                    div_by_zero <= dz;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
